// File: rtl/client_tx_sender_pkg.sv
// Shared types and defaults for the client TX sender.
// State encoding plus default IFG, retry and length-width constants.
package client_tx_sender_pkg;

  localparam logic [7:0] IFG_DELAY_DEF = 8'd12;
  localparam int         MAX_RETRY_DEF = 15;
  localparam int         LEN_W_DEF     = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    WAIT_ACK = 3'd2,
    STREAM   = 3'd3,
    GAP      = 3'd4
  } state_e;

endpackage

// File: rtl/client_tx_sender_if.sv
// Frame-source, frame-buffer and MAC client signals of the TX sender.
// master = sender side, slave = source/buffer/MAC side.
interface client_tx_sender_if #(
  parameter int LEN_W = 11
) ();

  logic             frm_valid;
  logic [LEN_W-1:0] frm_len;
  logic             frm_abort;
  logic             frm_start;
  logic             frm_done;
  logic             frm_drop;
  logic [LEN_W-1:0] buf_addr;
  logic [7:0]       buf_data;
  logic [7:0]       clientemactxd;
  logic             clientemactxdvld;
  logic             emacclienttxack;
  logic             clientemactxunderrun;
  logic             emacclienttxcollision;
  logic             emacclienttxretransmit;
  logic [7:0]       clientemactxifgdelay;

  modport master (
    input  frm_valid, frm_len, frm_abort,
    input  buf_data,
    input  emacclienttxack,
    input  emacclienttxcollision,
    input  emacclienttxretransmit,
    output frm_start, frm_done, frm_drop,
    output buf_addr,
    output clientemactxd, clientemactxdvld,
    output clientemactxunderrun,
    output clientemactxifgdelay
  );

  modport slave (
    output frm_valid, frm_len, frm_abort,
    output buf_data,
    output emacclienttxack,
    output emacclienttxcollision,
    output emacclienttxretransmit,
    input  frm_start, frm_done, frm_drop,
    input  buf_addr,
    input  clientemactxd, clientemactxdvld,
    input  clientemactxunderrun,
    input  clientemactxifgdelay
  );

endinterface

// File: rtl/client_tx_retry_cnt.sv
// Per-frame retransmission counter.
// Saturates at MAX_RETRY and flags when the limit is reached.
module client_tx_retry_cnt #(
  parameter int MAX_RETRY = 15,
  parameter int W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == W'(MAX_RETRY));

  // next count: clear on new frame, bump on retransmit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/client_tx_sender.sv
// Streams frames from a byte buffer to an Ethernet MAC client port.
// Handles ack wait, collision retransmit, abort underrun and drop.
module client_tx_sender
  import client_tx_sender_pkg::*;
#(
  parameter logic [7:0] IFG_DELAY = IFG_DELAY_DEF,
  parameter int         MAX_RETRY = MAX_RETRY_DEF,
  parameter int         LEN_W     = LEN_W_DEF
) (
  input logic                txcoreclk,
  input logic                reset,
  client_tx_sender_if.master tx
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] addr_q, addr_d;
  logic [7:0]       txd_q, txd_d;
  logic             dvld_q, dvld_d;
  logic             undr_q, undr_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             rc_clr, rc_inc, rc_max;
  logic             last;

  client_tx_retry_cnt #(
    .MAX_RETRY(MAX_RETRY)
  ) u_retry (
    .clk_i   (txcoreclk),
    .rst_i   (reset),
    .clr_i   (rc_clr),
    .inc_i   (rc_inc),
    .at_max_o(rc_max)
  );

  // buf_addr runs one ahead of the byte on the bus,
  // so the byte on the bus is the last one when it equals len
  assign last = (addr_q == len_q);

  // next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    txd_d   = txd_q;
    dvld_d  = dvld_q;
    undr_d  = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    rc_clr  = 1'b0;
    rc_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        dvld_d = 1'b0;
        txd_d  = '0;
        addr_d = '0;
        // drop_q guard: the source needs a cycle to
        // withdraw a rejected zero-length request
        if (tx.frm_valid && !drop_q) begin
          if (tx.frm_len == '0) begin
            drop_d = 1'b1;
          end else begin
            start_d = 1'b1;
            len_d   = tx.frm_len;
            rc_clr  = 1'b1;
            state_d = PREFETCH;
          end
        end
      end
      PREFETCH: begin
        txd_d   = tx.buf_data;
        dvld_d  = 1'b1;
        addr_d  = LEN_W'(1);
        state_d = WAIT_ACK;
      end
      WAIT_ACK, STREAM: begin
        if (undr_q) begin
          dvld_d  = 1'b0;
          txd_d   = '0;
          addr_d  = '0;
          drop_d  = 1'b1;
          state_d = IDLE;
        end else if (tx.emacclienttxcollision) begin
          dvld_d = 1'b0;
          txd_d  = '0;
          addr_d = '0;
          if (tx.emacclienttxretransmit && !rc_max) begin
            rc_inc  = 1'b1;
            state_d = GAP;
          end else begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (tx.frm_abort) begin
          undr_d = 1'b1;
        end else if (state_q == STREAM ||
                     tx.emacclienttxack) begin
          if (last) begin
            dvld_d  = 1'b0;
            txd_d   = '0;
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            txd_d   = tx.buf_data;
            addr_d  = addr_q + LEN_W'(1);
            state_d = STREAM;
          end
        end
      end
      GAP: begin
        dvld_d  = 1'b0;
        txd_d   = '0;
        addr_d  = '0;
        state_d = PREFETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge txcoreclk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      txd_q   <= '0;
      dvld_q  <= 1'b0;
      undr_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      txd_q   <= txd_d;
      dvld_q  <= dvld_d;
      undr_q  <= undr_d;
      start_q <= start_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign tx.frm_start            = start_q;
  assign tx.frm_done             = done_q;
  assign tx.frm_drop             = drop_q;
  assign tx.buf_addr             = addr_q;
  assign tx.clientemactxd        = txd_q;
  assign tx.clientemactxdvld     = dvld_q;
  assign tx.clientemactxunderrun = undr_q;
  assign tx.clientemactxifgdelay = IFG_DELAY;

endmodule

// File: tb/tb_client_tx_sender.sv
// Directed bench for client_tx_sender.
// Expected frame bytes are queued at frame start and popped as sent.
module tb_client_tx_sender;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc;

  logic [7:0] mem [0:2047];
  logic [7:0] exp_q [$];

  client_tx_sender_if #(.LEN_W(11)) bus ();

  client_tx_sender #(
    .IFG_DELAY(8'd12),
    .MAX_RETRY(15),
    .LEN_W    (11)
  ) dut (
    .txcoreclk(clk),
    .reset    (rst),
    .tx       (bus)
  );

  always #5 clk = ~clk;

  assign bus.buf_data = mem[bus.buf_addr];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic reload(input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic start_frame(input int len, input int seed);
    for (int i = 0; i < len; i++) mem[i] = 8'(i * 3 + seed + 1);
    reload(len);
    bus.frm_valid = 1'b1;
    bus.frm_len   = 11'(len);
    step();
    chk("start_pulse", bus.frm_start, 1);
    chk("prefetch_dvld", bus.clientemactxdvld, 0);
    chk("prefetch_addr", bus.buf_addr, 0);
    bus.frm_valid = 1'b0;
  endtask

  // ncyc = dvld-high cycles seen; stop_at = dvld cycle index
  // at which to hand control back (event injected there)
  task automatic stream(input int ack_dly, input int stop_at,
                        output int nc);
    bit acked = 0;
    nc = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      bus.emacclienttxack = 1'b0;
      if (acked && exp_q.size() == 0) begin
        chk("end_dvld", bus.clientemactxdvld, 0);
        chk("end_txd", bus.clientemactxd, 0);
        chk("end_done", bus.frm_done, 1);
        nc = i;
        return;
      end
      chk("dvld", bus.clientemactxdvld, 1);
      chk("txd", bus.clientemactxd, exp_q[0]);
      chk("no_done", bus.frm_done, 0);
      if (i == stop_at) begin
        nc = i;
        return;
      end
      if (acked) begin
        void'(exp_q.pop_front());
      end else if (i == ack_dly) begin
        bus.emacclienttxack = 1'b1;
        acked = 1;
        void'(exp_q.pop_front());
      end
    end
    chk("stream_timeout", 0, 1);
  endtask

  task automatic collide(input bit retx);
    bus.emacclienttxcollision  = 1'b1;
    bus.emacclienttxretransmit = retx;
    step();
    bus.emacclienttxcollision  = 1'b0;
    bus.emacclienttxretransmit = 1'b0;
    chk("coll_dvld", bus.clientemactxdvld, 0);
    chk("coll_txd", bus.clientemactxd, 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.frm_valid              = 1'b0;
    bus.frm_len                = '0;
    bus.frm_abort              = 1'b0;
    bus.emacclienttxack        = 1'b0;
    bus.emacclienttxcollision  = 1'b0;
    bus.emacclienttxretransmit = 1'b0;
    step();
    step();
    chk("rst_dvld", bus.clientemactxdvld, 0);
    chk("rst_txd", bus.clientemactxd, 0);
    chk("rst_addr", bus.buf_addr, 0);
    chk("rst_pulses", {bus.frm_start, bus.frm_done,
                       bus.frm_drop, bus.clientemactxunderrun}, 0);
    chk("ifg", bus.clientemactxifgdelay, 12);
    rst = 1'b0;
    step();

    // L=60, ack 3 cycles after dvld
    start_frame(60, 5);
    stream(3, -1, ncyc);
    chk("l60_dvld_cycles", ncyc, 63);
    step();
    chk("l60_done_once", bus.frm_done, 0);

    // L=1, immediate ack
    start_frame(1, 9);
    stream(0, -1, ncyc);
    chk("l1_dvld_cycles", ncyc, 1);
    step();

    // zero length: drop, no start
    bus.frm_valid = 1'b1;
    bus.frm_len   = '0;
    step();
    bus.frm_valid = 1'b0;
    chk("z_drop", bus.frm_drop, 1);
    chk("z_start", bus.frm_start, 0);
    step();
    chk("z_drop_once", bus.frm_drop, 0);
    chk("z_dvld", bus.clientemactxdvld, 0);

    // L=100, collision+retransmit at byte 20
    start_frame(100, 17);
    stream(2, 22, ncyc);
    collide(1'b1);
    chk("c_gap_drop", bus.frm_drop, 0);
    step();
    chk("c_pf_dvld", bus.clientemactxdvld, 0);
    chk("c_pf_start", bus.frm_start, 0);
    reload(100);
    stream(1, -1, ncyc);
    chk("c_resend_cycles", ncyc, 101);
    step();

    // L=64, collision without retransmit at byte 10
    start_frame(64, 33);
    stream(1, 11, ncyc);
    collide(1'b0);
    chk("nr_drop", bus.frm_drop, 1);
    chk("nr_done", bus.frm_done, 0);
    step();
    chk("nr_drop_once", bus.frm_drop, 0);
    chk("nr_no_resend", bus.clientemactxdvld, 0);
    step();
    chk("nr_idle_dvld", bus.clientemactxdvld, 0);

    // 16 consecutive collisions with retransmit
    start_frame(8, 51);
    for (int r = 0; r < 16; r++) begin
      stream(1, 2, ncyc);
      collide(1'b1);
      if (r < 15) begin
        chk("rt_gap_drop", bus.frm_drop, 0);
        step();
        chk("rt_pf_dvld", bus.clientemactxdvld, 0);
        reload(8);
      end else begin
        chk("rt_final_drop", bus.frm_drop, 1);
      end
    end
    step();
    chk("rt_idle_dvld", bus.clientemactxdvld, 0);

    // retry count cleared on the next frame
    start_frame(4, 70);
    stream(0, 1, ncyc);
    collide(1'b1);
    chk("rc_clr_drop", bus.frm_drop, 0);
    step();
    reload(4);
    stream(0, -1, ncyc);
    chk("rc_clr_cycles", ncyc, 4);
    step();

    // abort at byte 30
    start_frame(40, 90);
    stream(2, 32, ncyc);
    bus.frm_abort = 1'b1;
    step();
    bus.frm_abort = 1'b0;
    chk("ab_underrun", bus.clientemactxunderrun, 1);
    chk("ab_dvld", bus.clientemactxdvld, 1);
    chk("ab_drop_early", bus.frm_drop, 0);
    step();
    chk("ab_underrun_off", bus.clientemactxunderrun, 0);
    chk("ab_dvld_off", bus.clientemactxdvld, 0);
    chk("ab_drop", bus.frm_drop, 1);
    chk("ab_txd", bus.clientemactxd, 0);
    step();
    chk("ab_drop_once", bus.frm_drop, 0);

    // reset at byte 5
    start_frame(20, 110);
    stream(0, 5, ncyc);
    rst = 1'b1;
    step();
    chk("rs_dvld", bus.clientemactxdvld, 0);
    chk("rs_txd", bus.clientemactxd, 0);
    chk("rs_addr", bus.buf_addr, 0);
    chk("rs_pulses", {bus.frm_done, bus.frm_drop}, 0);
    rst = 1'b0;
    step();
    chk("rs_after_dvld", bus.clientemactxdvld, 0);
    chk("rs_after_pulses", {bus.frm_done, bus.frm_drop}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
